// File: rtl/i2f_pair_fsm_if.sv
// Handshake and operand bundle between the integer source, the converter
// and the downstream floating-point divider.
interface i2f_pair_fsm_if;
   logic        r_i;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] n;
   logic [31:0] x;
   logic        r_o;
   logic        busy;

   // The requester drives the start strobe and both integers
   modport master (
      output r_i,
      output a,
      output b,
      input  n,
      input  x,
      input  r_o,
      input  busy
   );

   // The converter consumes the integers and returns both floats
   modport slave (
      input  r_i,
      input  a,
      input  b,
      output n,
      output x,
      output r_o,
      output busy
   );
endinterface

// File: rtl/i2f_pair_fsm.sv
// Converts a pair of signed 32-bit integers into IEEE-754 single-precision
// values using one shared normaliser/rounder, operand A first, then B.
// Both results are published together with a one-cycle r_o pulse.
module i2f_pair_fsm (
   input  logic          clk,
   input  logic          rst_n,
   i2f_pair_fsm_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD_A  = 4'd1,
      NORM_A  = 4'd2,
      ROUND_A = 4'd3,
      PACK_A  = 4'd4,
      LOAD_B  = 4'd5,
      NORM_B  = 4'd6,
      ROUND_B = 4'd7,
      PACK_B  = 4'd8,
      DONE    = 4'd9
   } state_t;

   state_t state;
   state_t state_next;

   // Latched operands, shared working registers and per-operand results
   logic [31:0] a_reg;
   logic [31:0] b_reg;
   logic        sign;
   logic [31:0] mag;
   logic [5:0]  sh;
   logic [31:0] packed_word;
   logic [31:0] res_a;
   logic [31:0] n_reg;
   logic [31:0] x_reg;

   // Combinational helpers for the shared datapath
   logic        op_b;
   logic [31:0] load_v;
   logic        load_sign;
   logic [31:0] load_mag;
   logic        load_zero;
   logic [22:0] rnd_mant;
   logic        rnd_guard;
   logic        rnd_sticky;
   logic        rnd_inc;
   logic [23:0] rnd_sum;
   logic [7:0]  rnd_exp;
   logic [7:0]  rnd_exp_final;
   logic [22:0] rnd_mant_final;
   logic        out_busy;
   logic        out_r_o;

   // Operand select and the sign/magnitude split used by both LOAD states
   always_comb begin
      op_b      = (state inside {LOAD_B, NORM_B, ROUND_B, PACK_B});
      load_v    = op_b ? b_reg : a_reg;
      load_sign = load_v[31];
      load_mag  = load_sign ? (32'd0 - load_v) : load_v;
      load_zero = (load_mag == 32'd0);
   end

   // Round-to-nearest-even on the normalised magnitude; a carry out of the
   // mantissa bumps the exponent, which can never reach the all-ones code
   always_comb begin
      rnd_mant       = mag[30:8];
      rnd_guard      = mag[7];
      rnd_sticky     = |mag[6:0];
      rnd_inc        = rnd_guard & (rnd_sticky | rnd_mant[0]);
      rnd_sum        = {1'b0, rnd_mant} + {23'd0, rnd_inc};
      rnd_exp        = 8'd158 - {2'b00, sh};
      rnd_exp_final  = rnd_exp;
      rnd_mant_final = rnd_sum[22:0];
      if (rnd_sum[23]) begin
         rnd_exp_final  = rnd_exp + 8'd1;
         rnd_mant_final = 23'd0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic; a zero operand skips straight from LOAD to PACK and
   // NORM loops one bit per cycle until the leading one reaches bit 31
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (bus.r_i) state_next = LOAD_A;
         LOAD_A:  state_next = load_zero ? PACK_A : NORM_A;
         NORM_A:  state_next = mag[31] ? ROUND_A : NORM_A;
         ROUND_A: state_next = PACK_A;
         PACK_A:  state_next = LOAD_B;
         LOAD_B:  state_next = load_zero ? PACK_B : NORM_B;
         NORM_B:  state_next = mag[31] ? ROUND_B : NORM_B;
         ROUND_B: state_next = PACK_B;
         PACK_B:  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode: busy everywhere but IDLE, r_o only for the DONE cycle
   always_comb begin
      out_busy = (state != IDLE);
      out_r_o  = (state == DONE);
   end

   // Datapath registers; n and x only change on the edge entering DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_reg       <= 32'd0;
         b_reg       <= 32'd0;
         sign        <= 1'b0;
         mag         <= 32'd0;
         sh          <= 6'd0;
         packed_word <= 32'd0;
         res_a       <= 32'd0;
         n_reg       <= 32'd0;
         x_reg       <= 32'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.r_i) begin
                  a_reg <= bus.a;
                  b_reg <= bus.b;
               end
            end
            LOAD_A, LOAD_B: begin
               sign <= load_sign;
               mag  <= load_mag;
               sh   <= 6'd0;
               if (load_zero) begin
                  packed_word <= 32'd0;
               end
            end
            NORM_A, NORM_B: begin
               if (!mag[31]) begin
                  mag <= {mag[30:0], 1'b0};
                  sh  <= sh + 6'd1;
               end
            end
            ROUND_A, ROUND_B: begin
               packed_word <= {sign, rnd_exp_final, rnd_mant_final};
            end
            PACK_A: begin
               res_a <= packed_word;
            end
            PACK_B: begin
               n_reg <= res_a;
               x_reg <= packed_word;
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.n    = n_reg;
   assign bus.x    = x_reg;
   assign bus.r_o  = out_r_o;
   assign bus.busy = out_busy;

endmodule

// File: tb/tb_i2f_pair_fsm.sv
// Directed self-checking bench for i2f_pair_fsm: hand-computed floats and
// latencies for conversion, rounding, busy-ignore and reset-abort cases.
module tb_i2f_pair_fsm;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [31:0] prev_n;
   logic [31:0] prev_x;

   i2f_pair_fsm_if bus ();

   i2f_pair_fsm dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point; counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s observed=%h required=%h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the r_o pulse, checks latency, results, that the
   // outputs held mid-conversion, and that the pulse is exactly one cycle
   task automatic waitDone(input string tag, input int exp_lat,
                           input logic [31:0] exp_n, input logic [31:0] exp_x);
      int  lat;
      bit  got;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 120) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.r_o) got = 1'b1;
         else if (lat == 3) begin
            checkOutput({tag, "_n_hold"}, bus.n, prev_n);
            checkOutput({tag, "_x_hold"}, bus.x, prev_x);
         end
      end
      checkOutput({tag, "_latency"}, lat, exp_lat);
      checkOutput({tag, "_n"}, bus.n, exp_n);
      checkOutput({tag, "_x"}, bus.x, exp_x);
      @(posedge clk);
      #1;
      checkOutput({tag, "_r_o_fall"}, {31'd0, bus.r_o}, 32'd0);
      checkOutput({tag, "_busy_fall"}, {31'd0, bus.busy}, 32'd0);
      prev_n = exp_n;
      prev_x = exp_x;
   endtask

   // Issues a one-cycle start request (optionally held) and checks the result
   task automatic applyStimulus(input string tag, input logic [31:0] av, input logic [31:0] bv,
                                input int exp_lat, input logic [31:0] exp_n,
                                input logic [31:0] exp_x);
      @(negedge clk);
      bus.r_i = 1'b1;
      bus.a   = av;
      bus.b   = bv;
      @(posedge clk);
      #1;
      bus.r_i = 1'b0;
      checkOutput({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
      waitDone(tag, exp_lat, exp_n, exp_x);
   endtask

   initial begin
      int pulses;
      checks = 0;
      errors = 0;
      prev_n = 32'd0;
      prev_x = 32'd0;
      bus.r_i = 1'b0;
      bus.a   = 32'd0;
      bus.b   = 32'd0;
      rst_n   = 1'b0;
      #1;
      checkOutput("rst_n", bus.n, 32'd0);
      checkOutput("rst_x", bus.x, 32'd0);
      checkOutput("rst_r_o", {31'd0, bus.r_o}, 32'd0);
      checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      applyStimulus("basic", 32'd1, 32'hFFFF_FFFE, 69, 32'h3F80_0000, 32'hC000_0000);
      applyStimulus("zero_min", 32'd0, 32'h8000_0000, 6, 32'h0000_0000, 32'hCF00_0000);
      applyStimulus("round", 32'd16777217, 32'd16777219, 22, 32'h4B80_0000, 32'h4B80_0002);
      applyStimulus("carry", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 40, 32'h4F00_0000, 32'hBF80_0000);

      // Busy-ignore: r_i stays high with a=5 for the whole first conversion
      @(negedge clk);
      bus.r_i = 1'b1;
      bus.a   = 32'd1;
      bus.b   = 32'd1;
      @(posedge clk);
      #1;
      bus.a = 32'd5;
      waitDone("busy1", 70, 32'h3F80_0000, 32'h3F80_0000);
      @(posedge clk);
      #1;
      bus.r_i = 1'b0;
      checkOutput("busy2_restart", {31'd0, bus.busy}, 32'd1);
      waitDone("busy2", 68, 32'h40A0_0000, 32'h3F80_0000);

      // Reset abort while the B operand is normalising
      @(negedge clk);
      bus.r_i = 1'b1;
      bus.a   = 32'd0;
      bus.b   = 32'd1;
      @(posedge clk);
      #1;
      bus.r_i = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("abort_n", bus.n, 32'd0);
      checkOutput("abort_x", bus.x, 32'd0);
      checkOutput("abort_r_o", {31'd0, bus.r_o}, 32'd0);
      checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("abort_idle", {31'd0, bus.busy}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk);
         #1;
         if (bus.r_o) pulses++;
      end
      checkOutput("abort_no_pulse", pulses, 32'd0);
      prev_n = 32'd0;
      prev_x = 32'd0;
      applyStimulus("after_rst", 32'd3, 32'd4, 67, 32'h4040_0000, 32'h4080_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
